// File: rtl/data_c_lat_absorb_ram.sv
// data_c_lat_absorb_ram: DEPTH x DSIZE storage, one synchronous write port, one async read port.
//   clock   : write clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : read data (combinational)
module data_c_lat_absorb_ram #(
    parameter int DSIZE = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [DSIZE-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [DSIZE-1:0] o_rdata
);
    logic [DSIZE-1:0] r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/data_c_lat_absorb.sv
// data_c_lat_absorb: FWFT buffer absorbing a fixed-latency upstream pipe using a registered credit signal.
//   clock          : clock, rising edge
//   rst_n          : asynchronous active-low reset
//   i_slaver_valid : beat present from the upstream pipe (always written unless full)
//   i_slaver_data  : beat payload
//   o_slaver_ready : registered credit to the producer at the head of the pipe
//   o_master_valid : buffer non-empty
//   o_master_data  : head-of-buffer payload
//   i_master_ready : downstream accept
//   o_overflow     : sticky, set when a beat is dropped on a full buffer
module data_c_lat_absorb #(
    parameter int DSIZE = 8,
    parameter int LAT   = 4,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             i_slaver_valid,
    input  logic [DSIZE-1:0] i_slaver_data,
    output logic             o_slaver_ready,
    output logic             o_master_valid,
    output logic [DSIZE-1:0] o_master_data,
    input  logic             i_master_ready,
    output logic             o_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [CW-1:0] r_count;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic          r_ready;
    logic          r_overflow;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic [CW-1:0] w_count_next;

    assign w_full         = r_count == CW'(DEPTH);
    assign o_master_valid = r_count != '0;
    assign w_pop          = o_master_valid & i_master_ready;
    // A pop in the same cycle frees the slot, so a full buffer can still accept.
    assign w_push         = i_slaver_valid & (~w_full | w_pop);
    assign w_count_next   = r_count + CW'(w_push) - CW'(w_pop);
    assign o_slaver_ready = r_ready;
    assign o_overflow     = r_overflow;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ready    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_count  <= w_count_next;
            r_wr_ptr <= r_wr_ptr + AW'(w_push);
            r_rd_ptr <= r_rd_ptr + AW'(w_pop);
            // Leave room for LAT in-flight beats plus the one arriving now.
            r_ready  <= w_count_next <= CW'(DEPTH - 1 - LAT);
            if (i_slaver_valid & ~w_push) r_overflow <= 1'b1;
        end
    end

    data_c_lat_absorb_ram #(.DSIZE(DSIZE), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clock  (clock),
        .i_we   (w_push),
        .i_waddr(r_wr_ptr),
        .i_wdata(i_slaver_data),
        .i_raddr(r_rd_ptr),
        .o_rdata(o_master_data)
    );
endmodule

// File: tb/tb_data_c_lat_absorb.sv
// tb_data_c_lat_absorb: directed + randomized checks against a queue-based reference model.
module tb_data_c_lat_absorb;
    localparam int DSIZE = 8;
    localparam int LAT   = 4;
    localparam int DEPTH = 16;

    logic             clock = 1'b0;
    logic             rst_n = 1'b0;
    logic             i_slaver_valid = 1'b0;
    logic [DSIZE-1:0] i_slaver_data = '0;
    logic             o_slaver_ready;
    logic             o_master_valid;
    logic [DSIZE-1:0] o_master_data;
    logic             i_master_ready = 1'b0;
    logic             o_overflow;

    int checks = 0;
    int errors = 0;

    logic [DSIZE-1:0] q[$];
    logic             m_ovf = 1'b0;

    always #5 clock = ~clock;

    data_c_lat_absorb #(.DSIZE(DSIZE), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clock         (clock),
        .rst_n         (rst_n),
        .i_slaver_valid(i_slaver_valid),
        .i_slaver_data (i_slaver_data),
        .o_slaver_ready(o_slaver_ready),
        .o_master_valid(o_master_valid),
        .o_master_data (o_master_data),
        .i_master_ready(i_master_ready),
        .o_overflow    (o_overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check head before the edge, advance model, check registered outputs.
    task automatic step(input logic v, input logic [DSIZE-1:0] d, input logic mr,
                        output logic popped, output logic [DSIZE-1:0] pd);
        int sz;
        i_slaver_valid = v;
        i_slaver_data  = d;
        i_master_ready = mr;
        #1;
        chk("master_valid", o_master_valid, q.size() != 0);
        if (q.size() != 0) chk("master_data", o_master_data, q[0]);
        sz     = q.size();
        popped = (sz != 0) && mr;
        pd     = popped ? q[0] : '0;
        @(posedge clock);
        #1;
        if (popped) void'(q.pop_front());
        if (v) begin
            if (sz == DEPTH && !popped) m_ovf = 1'b1;
            else q.push_back(d);
        end
        chk("slaver_ready", o_slaver_ready, q.size() <= DEPTH - 1 - LAT);
        chk("overflow", o_overflow, m_ovf);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #2;
        rst_n = 1'b0;
        i_slaver_valid = 1'b1;
        i_slaver_data  = 8'hC3;
        #1;
        chk("rst_master_valid", o_master_valid, 1'b0);
        chk("rst_slaver_ready", o_slaver_ready, 1'b0);
        chk("rst_overflow", o_overflow, 1'b0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        q.delete();
        m_ovf = 1'b0;
        i_slaver_valid = 1'b0;
        i_master_ready = 1'b0;
        rst_n = 1'b1;
        @(posedge clock);
        #1;
        chk("post_rst_ready", o_slaver_ready, 1'b1);
        chk("post_rst_valid", o_master_valid, 1'b0);
    endtask

    initial begin
        logic             p;
        logic [DSIZE-1:0] pd;
        logic             pipe[$];
        logic [DSIZE-1:0] nxt;
        int               peak;
        int               sent;
        int               exp_out;
        int               guard;

        // Single beat 0x5A with downstream ready.
        do_reset();
        step(1'b1, 8'h5A, 1'b1, p, pd);
        chk("one_beat_valid", o_master_valid, 1'b1);
        chk("one_beat_data", o_master_data, 8'h5A);
        step(1'b0, '0, 1'b1, p, pd);
        chk("one_beat_pop", {p, pd}, {1'b1, 8'h5A});

        // Compliant upstream with LAT-cycle credit loop, downstream stalled.
        do_reset();
        pipe = {1'b0, 1'b0, 1'b0, 1'b0};
        nxt  = '0;
        peak = 0;
        for (int i = 0; i < 40; i++) begin
            logic vv;
            pipe.push_back(o_slaver_ready);
            vv = pipe.pop_front();
            step(vv, nxt, 1'b0, p, pd);
            if (vv) nxt++;
            if (q.size() > peak) peak = q.size();
        end
        chk("credit_peak", peak, DEPTH);
        chk("credit_no_ovf", o_overflow, 1'b0);

        // Full buffer: simultaneous push and pop keeps count at DEPTH.
        step(1'b1, 8'hA0, 1'b1, p, pd);
        chk("full_pushpop_pop", {p, pd}, {1'b1, 8'h00});
        chk("full_pushpop_cnt", q.size(), DEPTH);
        step(1'b1, 8'hA1, 1'b1, p, pd);
        chk("full_pushpop_ovf", o_overflow, 1'b0);
        guard = 0;
        while (q.size() != 0 && guard < 100) begin
            step(1'b0, '0, 1'b1, p, pd);
            guard++;
        end
        chk("drain_done", q.size(), 0);

        // 40 sequential beats with random downstream ready.
        do_reset();
        sent = 0;
        exp_out = 0;
        guard = 0;
        while ((sent < 40 || q.size() != 0) && guard < 2000) begin
            logic vv;
            vv = sent < 40 && q.size() < DEPTH;
            step(vv, DSIZE'(sent), 1'($urandom_range(1)), p, pd);
            if (vv) sent++;
            if (p) begin
                chk("order", pd, DSIZE'(exp_out));
                exp_out++;
            end
            guard++;
        end
        chk("order_count", exp_out, 40);

        // Forced push on full buffer without pop drops the beat.
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, DSIZE'($urandom), 1'b0, p, pd);
        step(1'b1, 8'hEE, 1'b0, p, pd);
        chk("drop_ovf", o_overflow, 1'b1);
        for (int i = 0; i < 20; i++) step(1'($urandom_range(1)), DSIZE'($urandom), 1'b1, p, pd);
        chk("ovf_sticky", o_overflow, 1'b1);

        // Mid-operation reset with 5 beats buffered.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, DSIZE'($urandom), 1'b0, p, pd);
        chk("pre_rst_valid", o_master_valid, 1'b1);
        do_reset();
        step(1'b0, '0, 1'b1, p, pd);
        chk("post_rst_empty", o_master_valid, 1'b0);

        // Random traffic soak.
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(1)), DSIZE'($urandom), 1'($urandom_range(1)), p, pd);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
